multiplexor_display_7seg: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display that shares one `Deco_binario_7seg` decoder across all digits. It holds a double-buffered nibble frame, steps a one-hot digit enable through the digits with a programmable on-time and inter-digit blanking gap, and presents the selected nibble to the decoder's `i_Bits`. It sits between the numeric datapath (counters, ALU results) and the board display pins.

---
 rtl/multiplexor_display_7seg.sv | 160 ++++++++++++++++
 tb/tb_multiplexor_display_7seg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_display_7seg.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Double-buffered nibble frame; one-hot anodes with a blanking gap before each digit.
//
// state     | meaning
// INACTIVO  | scan disabled, display dark, index and counter parked at 0
// APAGADO   | all anodes off, o_Bits already shows the current digit
// ENCENDIDO | current digit lit (unless zero-suppressed)
module multiplexor_display_7seg #(
  parameter int N_DIGITOS          = 4,
  parameter int CUENTAS_POR_DIGITO = 50000,
  parameter int CUENTAS_APAGADO    = 16
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_n,
  input  logic                         i_Habilitar,
  input  logic [4*N_DIGITOS-1:0]       i_Datos,
  input  logic                         i_Cargar,
  input  logic                         i_Supresion_ceros,
  output logic [3:0]                   o_Bits,
  output logic [N_DIGITOS-1:0]         o_Anodos,
  output logic [$clog2(N_DIGITOS)-1:0] o_Digito,
  output logic                         o_Fin_barrido
);

  localparam int W_IDX   = $clog2(N_DIGITOS);
  localparam int CNT_MAX = (CUENTAS_POR_DIGITO > CUENTAS_APAGADO) ? CUENTAS_POR_DIGITO
                                                                  : CUENTAS_APAGADO;
  localparam int W_CNT   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [W_CNT-1:0] CARGA_ON  = W_CNT'(CUENTAS_POR_DIGITO - 1);
  localparam logic [W_CNT-1:0] CARGA_OFF = W_CNT'(CUENTAS_APAGADO - 1);
  localparam logic [W_IDX-1:0] ULTIMO    = W_IDX'(N_DIGITOS - 1);

  typedef enum logic [1:0] {INACTIVO, APAGADO, ENCENDIDO} estado_t;

  estado_t                 state_q, state_d;
  logic [W_IDX-1:0]        idx_q, idx_d;
  logic [W_CNT-1:0]        cnt_q, cnt_d;
  logic [4*N_DIGITOS-1:0]  activo_q, activo_d;
  logic [4*N_DIGITOS-1:0]  pendiente_q, pendiente_d;
  logic                    bandera_q, bandera_d;
  logic [3:0]              bits_q, bits_d;
  logic [N_DIGITOS-1:0]    anodos_q, anodos_d;
  logic                    fin_q, fin_d;

  function automatic logic [3:0] nibble(input logic [4*N_DIGITOS-1:0] f,
                                        input logic [W_IDX-1:0] k);
    nibble = 4'h0;
    for (int i = 0; i < N_DIGITOS; i++)
      if (k == W_IDX'(i)) nibble = f[4*i +: 4];
  endfunction

  // Digit k is blank when it and every more significant nibble are zero; digit 0 always shows.
  function automatic logic suprimido(input logic [4*N_DIGITOS-1:0] f,
                                     input logic [W_IDX-1:0] k);
    suprimido = (k != '0);
    for (int i = 0; i < N_DIGITOS; i++)
      if (W_IDX'(i) >= k && f[4*i +: 4] != 4'h0) suprimido = 1'b0;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= INACTIVO;
      idx_q       <= '0;
      cnt_q       <= '0;
      activo_q    <= '0;
      pendiente_q <= '0;
      bandera_q   <= 1'b0;
      bits_q      <= 4'h0;
      anodos_q    <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      activo_q    <= activo_d;
      pendiente_q <= pendiente_d;
      bandera_q   <= bandera_d;
      bits_q      <= bits_d;
      anodos_q    <= anodos_d;
      fin_q       <= fin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    activo_d    = activo_q;
    pendiente_d = pendiente_q;
    bandera_d   = bandera_q;
    bits_d      = bits_q;
    anodos_d    = anodos_q;
    fin_d       = 1'b0;

    if (i_Cargar) begin
      pendiente_d = i_Datos;
      bandera_d   = 1'b1;
    end

    if (!i_Habilitar) begin
      state_d  = INACTIVO;
      idx_d    = '0;
      cnt_d    = '0;
      anodos_d = '0;
    end else begin
      case (state_q)
        INACTIVO: begin
          state_d  = APAGADO;
          idx_d    = '0;
          cnt_d    = CARGA_OFF;
          bits_d   = nibble(activo_q, '0);
          anodos_d = '0;
        end
        APAGADO: begin
          if (cnt_q == '0) begin
            state_d  = ENCENDIDO;
            cnt_d    = CARGA_ON;
            anodos_d = (i_Supresion_ceros && suprimido(activo_q, idx_q))
                       ? '0 : (N_DIGITOS'(1) << idx_q);
          end else begin
            cnt_d = cnt_q - W_CNT'(1);
          end
        end
        ENCENDIDO: begin
          if (cnt_q == '0) begin
            state_d  = APAGADO;
            cnt_d    = CARGA_OFF;
            anodos_d = '0;
            if (idx_q == ULTIMO) begin
              // Frame swap happens only here, so a scan never mixes two frames.
              idx_d = '0;
              fin_d = 1'b1;
              if (i_Cargar) begin
                activo_d  = i_Datos;
                bandera_d = 1'b0;
              end else if (bandera_q) begin
                activo_d  = pendiente_q;
                bandera_d = 1'b0;
              end
              bits_d = nibble(activo_d, '0);
            end else begin
              idx_d  = idx_q + W_IDX'(1);
              bits_d = nibble(activo_q, idx_q + W_IDX'(1));
            end
          end else begin
            cnt_d = cnt_q - W_CNT'(1);
          end
        end
        default: state_d = INACTIVO;
      endcase
    end
  end

  assign o_Bits        = bits_q;
  assign o_Anodos      = anodos_q;
  assign o_Digito      = idx_q;
  assign o_Fin_barrido = fin_q;

endmodule

// File: tb/tb_multiplexor_display_7seg.sv
// Bench for multiplexor_display_7seg: directed scenarios with random frames,
// compared cycle by cycle against a position-in-scan reference model.
module tb_multiplexor_display_7seg;
  localparam int N    = 4;
  localparam int P    = 8;
  localparam int A    = 2;
  localparam int DIG  = P + A;
  localparam int SCAN = N * DIG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hab = 1'b0;
  logic        cargar = 1'b0;
  logic        sup = 1'b0;
  logic [15:0] datos = 16'h0;
  logic [3:0]  bits;
  logic [3:0]  anod;
  logic [1:0]  dig;
  logic        fin;

  int checks = 0;
  int errors = 0;

  // Reference model: position counted from the enabling edge decides digit and phase.
  bit          m_on = 1'b0;
  int          pos = 0;
  logic [15:0] act = 16'h0;
  logic [15:0] pend = 16'h0;
  bit          pflag = 1'b0;
  logic [3:0]  e_bits = 4'h0;
  logic [3:0]  e_lat = 4'h0;

  always #5 clk = ~clk;

  multiplexor_display_7seg #(
    .N_DIGITOS(N), .CUENTAS_POR_DIGITO(P), .CUENTAS_APAGADO(A)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Habilitar(hab), .i_Datos(datos),
    .i_Cargar(cargar), .i_Supresion_ceros(sup), .o_Bits(bits),
    .o_Anodos(anod), .o_Digito(dig), .o_Fin_barrido(fin)
  );

  function automatic bit suprime(logic [15:0] f, int d, bit s);
    return s && (d != 0) && ((f >> (4 * d)) == 16'h0);
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; pos = 0; act = 0; pend = 0; pflag = 0; e_bits = 0; e_lat = 0;
  endtask

  task automatic tick();
    logic hb, cg, sp;
    logic [15:0] dt;
    bit wrap;
    int d, ph;
    hb = hab; cg = cargar; sp = sup; dt = datos;
    @(posedge clk);
    wrap = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!hb) m_on = 0;
      else if (!m_on) begin m_on = 1; pos = 0; end
      else begin pos++; wrap = (pos % SCAN == 0); end
      if (wrap && cg) begin act = dt; pflag = 0; end
      else if (wrap && pflag) begin act = pend; pflag = 0; end
      else if (cg) begin pend = dt; pflag = 1; end
    end
    d  = (pos / DIG) % N;
    ph = pos % DIG;
    if (m_on) begin
      e_bits = act[4*d +: 4];
      if (ph == A) e_lat = suprime(act, d, sp) ? 4'h0 : 4'(1 << d);
    end
    #1;
    chk("bits",   bits, e_bits);
    chk("anodos", anod, (m_on && ph >= A) ? e_lat : 4'h0);
    chk("digito", dig,  m_on ? 2'(d) : 2'd0);
    chk("fin",    fin,  m_on && wrap);
  endtask

  task automatic load(logic [15:0] v);
    datos = v; cargar = 1; tick(); cargar = 0;
  endtask

  task automatic seek(int lo, int hi);
    for (int i = 0; i < 2 * SCAN; i++) begin
      if (m_on && (pos % SCAN) >= lo && (pos % SCAN) <= hi) break;
      tick();
    end
  endtask

  initial begin
    logic [15:0] fr;
    #2 rst_n = 0;
    #1;
    chk("rst_bits", bits, 0);
    chk("rst_anodos", anod, 0);
    chk("rst_digito", dig, 0);
    chk("rst_fin", fin, 0);
    tick(); tick();
    #3 rst_n = 1;

    // Basic scan: frame appears from the first wrap after enabling
    load(16'h4321);
    hab = 1;
    repeat (2 * SCAN + 5) tick();

    // Double buffer: load during digit 1 ON
    seek(12, 19);
    load(16'h9999);
    repeat (SCAN + 10) tick();

    // Bypass on the wrap edge
    seek(SCAN - 1, SCAN - 1);
    load(16'h0007);
    chk("bypass_bits", bits, 4'h7);
    repeat (SCAN) tick();

    // Zero suppression
    sup = 1;
    load(16'h0050);
    repeat (2 * SCAN) tick();
    load(16'h0000);
    repeat (2 * SCAN) tick();

    // Random frames with leading zeros, random loads and occasional enable drops
    for (int it = 0; it < 8; it++) begin
      sup = 1'($urandom_range(0, 1));
      for (int t = 0; t < SCAN + 20; t++) begin
        fr = 16'($urandom);
        fr = fr >> (4 * $urandom_range(0, 4));
        datos  = fr;
        cargar = ($urandom_range(0, 15) == 0);
        hab    = ($urandom_range(0, 63) != 0);
        tick();
      end
      cargar = 0; hab = 1;
    end

    // Enable drop during digit 2 ON, then restart with blanking first
    sup = 0;
    load(16'h4321);
    repeat (SCAN) tick();
    seek(22 + 1, 29);
    hab = 0;
    tick();
    chk("drop_anodos", anod, 0);
    chk("drop_digito", dig, 0);
    hab = 1;
    repeat (A + 1) tick();
    chk("reen_anodos", anod, 4'b0001);
    repeat (SCAN) tick();

    // Asynchronous reset mid-ON, between edges
    seek(A + 1, DIG - 1);
    #3 rst_n = 0;
    #1;
    chk("arst_bits", bits, 0);
    chk("arst_anodos", anod, 0);
    chk("arst_digito", dig, 0);
    chk("arst_fin", fin, 0);
    model_reset();
    hab = 0;
    tick(); tick();
    #3 rst_n = 1;
    load(16'($urandom));
    hab = 1;
    repeat (2 * SCAN) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
